// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the packed-BCD converters.
// Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

    // Converter FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    // Largest legal value of a single BCD digit
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // True when a nibble does not encode a decimal digit
    function automatic logic nibble_invalid(input logic [3:0] nib);
        return (nib > BCD_MAX_DIGIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_check.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_check
// Brief    : Combinational "any nibble above 9" detector for a packed BCD word.
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_check
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    output logic                any_bad_o
);

    logic [DIGITS-1:0] w_bad;

    // One comparator per digit position
    for (genvar k = 0; k < DIGITS; k++) begin : g_nibble
        assign w_bad[k] = nibble_invalid(bcd_i[4*k +: 4]);
    end

    assign any_bad_o = |w_bad;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Brief    : Sequential packed-BCD to binary converter. One digit per cycle,
//            most-significant first (acc = acc*10 + digit), valid/ready on
//            both sides, invalid-digit words yield 0 with an error flag.
// Revision : 1.0  initial release
// ============================================================================
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] in_bcd,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BIN_W-1:0]    out_bin,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int IN_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DIGITS);

    bcd_state_e          state_q;
    logic [IN_W-1:0]     sr_q;
    logic [BIN_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [BIN_W-1:0]    out_bin_q;
    logic                out_err_q;

    logic                w_any_bad;
    logic [BIN_W-1:0]    acc_d;

    // Error flag for the word currently offered on the input
    bcd_digit_check #(
        .DIGITS (DIGITS)
    ) u_check (
        .bcd_i     (in_bcd),
        .any_bad_o (w_any_bad)
    );

    // Multiply-by-ten as two shifts; the top nibble of the shift register is
    // the next digit to fold in. Wraps harmlessly on invalid words.
    always_comb begin
        acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(sr_q[IN_W-1 -: 4]);
    end

    // FSM, datapath and registered outputs. The CONV state spends one extra
    // cycle after the last digit (counter == DIGITS) to register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q       <= in_bcd;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        err_q      <= w_any_bad;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    if (cnt_q == c_last_cnt) begin
                        out_valid_q <= 1'b1;
                        out_bin_q   <= err_q ? '0 : acc_q;
                        out_err_q   <= err_q;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        sr_q  <= sr_q << 4;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_bin_q   <= '0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Brief    : Self-checking bench for bcd_to_bin (2-digit and 3-digit builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_to_bin;

    typedef struct {
        logic [9:0] bin;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] bin;
        logic       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  in_bcd;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  out_bin;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    logic [11:0] w_in_bcd;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [9:0]  w_out_bin;
    logic        w_out_err;
    logic        w_out_valid;
    logic        w_out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t nq[$];
    exp_t wq[$];

    always #5 clk = ~clk;

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bcd    (in_bcd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bcd    (w_in_bcd),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .out_bin   (w_out_bin),
        .out_err   (w_out_err),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] bin2bcd(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    // Scoreboard for the 2-digit build: pop on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (nq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = nq.pop_front();
                check("out_bin", 32'(out_bin), 32'(e.bin));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // Scoreboard for the 3-digit build
    always @(negedge clk) begin
        if (rst_n && w_out_valid && w_out_ready) begin
            if (wq.size() == 0) begin
                check("w_unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = wq.pop_front();
                check("w_out_bin", 32'(w_out_bin), 32'(e.bin));
                check("w_out_err", 32'(w_out_err), 32'(e.err));
            end
        end
    end

    // Offer one word to the 2-digit build; optionally check output latency
    task automatic send_n(input logic [7:0] bcd, input logic [6:0] eb, input logic ee,
                          input bit measure, input string nm);
        int w;
        int k;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({nm, "_in_ready"}, 32'(in_ready), 1);
        in_bcd   = bcd;
        in_valid = 1'b1;
        nq.push_back('{10'(eb), ee});
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (measure) begin
            k = 0;
            while (!out_valid && k < 10) begin
                @(posedge clk); #1; k++;
            end
            check({nm, "_latency"}, 32'(k), 3);
        end
    endtask

    // Offer one word to the 3-digit build and check its latency
    task automatic send_w(input logic [11:0] bcd, input logic [9:0] eb, input logic ee,
                          input string nm);
        int w;
        int k;
        w = 0;
        while (!w_in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({nm, "_in_ready"}, 32'(w_in_ready), 1);
        w_in_bcd   = bcd;
        w_in_valid = 1'b1;
        wq.push_back('{eb, ee});
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        k = 0;
        while (!w_out_valid && k < 10) begin
            @(posedge clk); #1; k++;
        end
        check({nm, "_latency"}, 32'(k), 4);
        @(posedge clk); #1;
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[10];
        int   w;
        bit   seen;

        vt[0] = '{8'h59, 7'd59, 1'b0};
        vt[1] = '{8'h00, 7'd0,  1'b0};
        vt[2] = '{8'h99, 7'd99, 1'b0};
        vt[3] = '{8'h10, 7'd10, 1'b0};
        vt[4] = '{8'h01, 7'd1,  1'b0};
        vt[5] = '{8'h5A, 7'd0,  1'b1};
        vt[6] = '{8'hF3, 7'd0,  1'b1};
        vt[7] = '{8'hA0, 7'd0,  1'b1};
        vt[8] = '{8'h9F, 7'd0,  1'b1};
        vt[9] = '{8'hFF, 7'd0,  1'b1};

        rst_n       = 1'b0;
        in_bcd      = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        w_in_bcd    = 12'h000;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_bin",   32'(out_bin),   0);
        check("rst_out_err",   32'(out_err),   0);
        check("rst_w_in_ready", 32'(w_in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of vectors, each with latency measured
        for (int i = 0; i < 10; i++) begin
            send_n(vt[i].bcd, vt[i].bin, vt[i].err, 1'b1, $sformatf("vec%0d", i));
        end

        // In_ready returns one cycle after the handoff
        @(posedge clk); #1;
        check("in_ready_after_handoff", 32'(in_ready), 1);

        // Loopback sweep: binary -> BCD model feeds the converter
        for (int n = 0; n < 100; n++) begin
            send_n(bin2bcd(n), 7'(n), 1'b0, 1'b0, "sweep");
        end
        w = 0;
        while (nq.size() != 0 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("sweep_drained", 32'(nq.size()), 0);

        // Backpressure with a concurrent ignored request
        out_ready = 1'b0;
        send_n(8'h42, 7'd42, 1'b0, 1'b0, "bp");
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clk); #1; w++;
        end
        in_bcd   = 8'h17;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_bin",   32'(out_bin),   42);
            check("bp_out_err",   32'(out_err),   0);
            check("bp_in_ready",  32'(in_ready),  0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_valid", 32'(out_valid), 0);
        check("bp_released_ready", 32'(in_ready),  1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("bp_no_phantom", 32'(seen), 0);

        // Reset in the middle of a conversion
        in_bcd   = 8'h77;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 32'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_bin",   32'(out_bin),   0);
        check("mid_rst_out_err",   32'(out_err),   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_out_valid", 32'(seen), 0);
        check("mid_in_ready", 32'(in_ready), 1);

        // Wide build
        send_w(12'h999, 10'd999, 1'b0, "w999");
        send_w(12'h100, 10'd100, 1'b0, "w100");
        send_w(12'h123, 10'd123, 1'b0, "w123");
        send_w(12'h09A, 10'd0,   1'b1, "w09A");

        // Post-check that both scoreboards drained
        send_n(8'h87, 7'd87, 1'b0, 1'b1, "last");
        repeat (3) @(posedge clk);
        #1;
        check("nq_empty", 32'(nq.size()), 0);
        check("wq_empty", 32'(wq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
